// File: rtl/uc_pkg.sv
// Shared types and constants for the hardwired control unit.
// Optional single-step support is enabled with UC_SINGLE_STEP_EN.
package uc_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_DEC  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_LOAD = 4'h9,
        OP_MOV  = 4'hA,
        OP_JMP  = 4'hB,
        OP_JZ   = 4'hC,
        OP_JC   = 4'hD,
        OP_JN   = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
`ifdef UC_SINGLE_STEP_EN
        S_PAUSE,
`endif
        S_HALT
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b1000;

    localparam logic [1:0] SH_PASS  = 2'b00;
    localparam logic [1:0] SH_LEFT  = 2'b01;
    localparam logic [1:0] SH_RIGHT = 2'b10;

    localparam int CW_A    = 14;
    localparam int CW_B    = 12;
    localparam int CW_D    = 10;
    localparam int CW_WE   = 9;
    localparam int CW_BSEL = 8;
    localparam int CW_G    = 4;
    localparam int CW_H    = 2;
    localparam int CW_MF   = 1;
    localparam int CW_MD   = 0;

    function automatic logic is_flag_op(input opcode_e op);
        return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_DEC});
    endfunction

endpackage

// File: rtl/contador_programa.sv
// Program counter: async reset, clear, target load and increment.
// Clear has priority over load, load over increment; wraps modulo 2^PC_W.
module contador_programa #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_ld,
    input  logic            i_inc,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (i_clr) begin
            r_pc <= '0;
        end else if (i_ld) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/unidad_control.sv
// Hardwired FETCH/DECODE/EXEC sequencer driving the 4-bit datapath.
// Define UC_SINGLE_STEP_EN to add the step input and PAUSE state.
module unidad_control
    import uc_pkg::*;
#(
    parameter int N    = 4,
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef UC_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [15:0]     instr,
    input  logic [3:0]      stateBits,
    output logic [PC_W-1:0] pc_out,
    output logic [15:0]     ctrl_word,
    output logic            busy,
    output logic            halted
);

    if ((N < 1) || (PC_W < 1) || (PC_W > 6)) begin : g_bad_cfg
        $error("unidad_control: illegal N or PC_W");
    end

    state_e      r_state;
    state_e      w_next;
    logic [15:0] r_ir;
    logic [15:0] r_ctrl;
    logic [3:0]  r_flag_q;
    logic        r_flag_pend;
    opcode_e     w_op;
    logic        w_take;
    logic        w_pc_clr;
    logic        w_pc_ld;
    logic        w_pc_inc;
    logic        w_unused;

    function automatic logic [15:0] decode(input logic [15:0] ir);
        logic [15:0] cw;
        cw = '0;
        cw[CW_A +: 2] = ir[9:8];
        cw[CW_B +: 2] = ir[7:6];
        cw[CW_D +: 2] = ir[11:10];
        cw[CW_WE]     = 1'b1;
        unique case (opcode_e'(ir[15:12]))
            OP_ADD:  cw[CW_G +: 4] = ALU_ADD;
            OP_SUB:  cw[CW_G +: 4] = ALU_SUB;
            OP_AND:  cw[CW_G +: 4] = ALU_AND;
            OP_OR:   cw[CW_G +: 4] = ALU_OR;
            OP_XOR:  cw[CW_G +: 4] = ALU_XOR;
            OP_DEC: begin
                cw[CW_BSEL]   = 1'b1;
                cw[CW_G +: 4] = ALU_ADD;
            end
            OP_SHL: begin
                cw[CW_H +: 2] = SH_LEFT;
                cw[CW_MF]     = 1'b1;
            end
            OP_SHR: begin
                cw[CW_H +: 2] = SH_RIGHT;
                cw[CW_MF]     = 1'b1;
            end
            OP_LOAD: cw[CW_MD] = 1'b1;
            OP_MOV: begin
                cw[CW_H +: 2] = SH_PASS;
                cw[CW_MF]     = 1'b1;
            end
            default: cw = '0;
        endcase
        return cw;
    endfunction

    assign w_op = opcode_e'(r_ir[15:12]);

    always_comb begin
        w_take = 1'b0;
        unique case (w_op)
            OP_JMP:  w_take = 1'b1;
            OP_JZ:   w_take = r_flag_q[0];
            OP_JC:   w_take = r_flag_q[1];
            OP_JN:   w_take = r_flag_q[3];
            default: w_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_pc_clr = 1'b0;
        w_pc_ld  = 1'b0;
        w_pc_inc = 1'b0;
        unique case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_next   = S_FETCH;
                    w_pc_clr = 1'b1;
                end
            end
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (w_op == OP_HALT) begin
                    w_next = S_HALT;
                end else begin
`ifdef UC_SINGLE_STEP_EN
                    w_next   = S_PAUSE;
`else
                    w_next   = S_FETCH;
`endif
                    w_pc_ld  = w_take;
                    w_pc_inc = !w_take;
                end
            end
`ifdef UC_SINGLE_STEP_EN
            S_PAUSE: if (step) w_next = S_FETCH;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // The cycle after EXEC (FETCH, or PAUSE) samples the flags of that op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir        <= '0;
            r_ctrl      <= '0;
            r_flag_q    <= '0;
            r_flag_pend <= 1'b0;
        end else begin
            if (r_state == S_FETCH) r_ir <= instr;
            r_ctrl <= (r_state == S_DECODE) ? decode(r_ir) : 16'h0000;
            if (r_state == S_EXEC) begin
                r_flag_pend <= is_flag_op(w_op);
            end else if (r_flag_pend) begin
                r_flag_q    <= stateBits;
                r_flag_pend <= 1'b0;
            end
        end
    end

    contador_programa #(
        .PC_W (PC_W)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_pc_clr),
        .i_ld     (w_pc_ld),
        .i_inc    (w_pc_inc),
        .i_target (r_ir[PC_W-1:0]),
        .o_pc     (pc_out)
    );

    assign ctrl_word = r_ctrl;
    assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted    = (r_state == S_HALT);
    assign w_unused  = ^{r_ir, r_flag_q};

endmodule

// File: tb/tb_unidad_control.sv
// Directed bench for unidad_control with a combinational ROM model.
// Adds a PAUSE/step sequence when UC_SINGLE_STEP_EN is defined.
module tb_unidad_control;

    logic        clk;
    logic        rst_n;
    logic        start;
`ifdef UC_SINGLE_STEP_EN
    logic        step;
`endif
    logic [15:0] instr;
    logic [3:0]  stateBits;
    logic [3:0]  pc_out;
    logic [15:0] ctrl_word;
    logic        busy;
    logic        halted;

    logic [15:0] rom [16];
    int          total;
    int          bad;

    assign instr = rom[pc_out];

    unidad_control #(
        .N    (4),
        .PC_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef UC_SINGLE_STEP_EN
        .step      (step),
`endif
        .instr     (instr),
        .stateBits (stateBits),
        .pc_out    (pc_out),
        .ctrl_word (ctrl_word),
        .busy      (busy),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] ins;
        logic [15:0] cw;
        logic [3:0]  nxt;
    } vec_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] fl;
        logic [3:0] pc;
    } br_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic rom_nops();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    vec_t vt[14];
    br_t  bt[6];

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        stateBits = 4'b0000;
`ifdef UC_SINGLE_STEP_EN
        step      = 1'b0;
`endif
        rom_nops();

        vt[0]  = '{4'd0,  16'h16C0, 16'hB600, 4'd1};
        vt[1]  = '{4'd1,  16'h2900, 16'h4A30, 4'd2};
        vt[2]  = '{4'd2,  16'h3F40, 16'hDE40, 4'd3};
        vt[3]  = '{4'd3,  16'h4180, 16'h6260, 4'd4};
        vt[4]  = '{4'd4,  16'h54C0, 16'h3680, 4'd5};
        vt[5]  = '{4'd5,  16'h6A00, 16'h8B00, 4'd6};
        vt[6]  = '{4'd6,  16'h7D80, 16'h6E06, 4'd7};
        vt[7]  = '{4'd7,  16'h8300, 16'hC20A, 4'd8};
        vt[8]  = '{4'd8,  16'h9440, 16'h1601, 4'd9};
        vt[9]  = '{4'd9,  16'hAB00, 16'hCA02, 4'd10};
        vt[10] = '{4'd10, 16'h0FC0, 16'h0000, 4'd11};
        vt[11] = '{4'd11, 16'hB6CE, 16'h0000, 4'd14};
        vt[12] = '{4'd14, 16'hC003, 16'h0000, 4'd15};
        vt[13] = '{4'd15, 16'h0000, 16'h0000, 4'd0};

        bt[0] = '{4'hC, 4'b0001, 4'd5};
        bt[1] = '{4'hC, 4'b0000, 4'd2};
        bt[2] = '{4'hD, 4'b0010, 4'd5};
        bt[3] = '{4'hD, 4'b1101, 4'd2};
        bt[4] = '{4'hE, 4'b1000, 4'd5};
        bt[5] = '{4'hE, 4'b0111, 4'd2};

        #3;
        chk("rst_pc", 16'(pc_out), 16'h0);
        chk("rst_cw", ctrl_word, 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 16'(busy), 16'h0);

        // decode table, one instruction per ROM slot
        for (int i = 0; i < 14; i++) rom[vt[i].addr] = vt[i].ins;
        go();
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("t%0d_pc", i), 16'(pc_out), 16'(vt[i].addr));
            chk($sformatf("t%0d_fetch_cw", i), ctrl_word, 16'h0);
            chk($sformatf("t%0d_busy", i), 16'(busy), 16'h1);
            tick();
            chk($sformatf("t%0d_dec_cw", i), ctrl_word, 16'h0);
            tick();
            chk($sformatf("t%0d_exec_cw", i), ctrl_word, vt[i].cw);
            chk($sformatf("t%0d_exec_pc", i), 16'(pc_out), 16'(vt[i].addr));
            tick();
            chk($sformatf("t%0d_next_pc", i), 16'(pc_out), 16'(vt[i].nxt));
        end

        // SUB then conditional branch, flags only valid in the following FETCH
        do_reset();
        rom_nops();
        rom[0] = 16'h2000;
        rom[2] = 16'hF000;
        rom[5] = 16'hF000;
        for (int i = 0; i < 6; i++) begin
            rom[1] = {bt[i].op, 12'h005};
            go();
            chk($sformatf("b%0d_start_pc", i), 16'(pc_out), 16'h0);
            chk($sformatf("b%0d_start_busy", i), 16'(busy), 16'h1);
            tick();
            tick();
            chk($sformatf("b%0d_sub_cw", i), ctrl_word, 16'h0230);
            tick();
            stateBits = bt[i].fl;
            tick();
            stateBits = 4'b0000;
            tick();
            chk($sformatf("b%0d_br_cw", i), ctrl_word, 16'h0);
            tick();
            chk($sformatf("b%0d_br_pc", i), 16'(pc_out), 16'(bt[i].pc));
            tick();
            tick();
            tick();
            chk($sformatf("b%0d_halted", i), 16'(halted), 16'h1);
            chk($sformatf("b%0d_halt_pc", i), 16'(pc_out), 16'(bt[i].pc));
        end

        // HALT at 3, start held high while busy
        do_reset();
        rom_nops();
        rom[3] = 16'hF000;
        start = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("h_busy_start_pc", 16'(pc_out), 16'h1);
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("h_halted", 16'(halted), 16'h1);
        chk("h_busy", 16'(busy), 16'h0);
        chk("h_pc", 16'(pc_out), 16'h3);
        for (int i = 0; i < 4; i++) tick();
        chk("h_pc_hold", 16'(pc_out), 16'h3);
        chk("h_cw", ctrl_word, 16'h0);
        go();
        chk("h_restart_pc", 16'(pc_out), 16'h0);
        chk("h_restart_busy", 16'(busy), 16'h1);
        chk("h_restart_halted", 16'(halted), 16'h0);

        // all NOP: three cycles per step, wrap 15 -> 0
        do_reset();
        rom_nops();
        go();
        for (int s = 0; s < 17; s++) begin
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("w%0d_%0d_pc", s, c), 16'(pc_out), 16'(s % 16));
                tick();
            end
        end

        // reset during EXEC of DEC
        do_reset();
        rom_nops();
        rom[0] = 16'h66C0;
        go();
        tick();
        tick();
        chk("r_exec_cw", ctrl_word, 16'hB700);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_cw", ctrl_word, 16'h0);
        chk("r_async_busy", 16'(busy), 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("r_post_pc", 16'(pc_out), 16'h0);
        chk("r_post_cw", ctrl_word, 16'h0);
        chk("r_post_busy", 16'(busy), 16'h0);
        chk("r_post_halted", 16'(halted), 16'h0);

`ifdef UC_SINGLE_STEP_EN
        do_reset();
        rom_nops();
        go();
        tick();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("p%0d_busy", i), 16'(busy), 16'h1);
            chk($sformatf("p%0d_cw", i), ctrl_word, 16'h0);
            chk($sformatf("p%0d_pc", i), 16'(pc_out), 16'h1);
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        tick();
        chk("p_next_pc", 16'(pc_out), 16'h2);
        tick();
        chk("p_still_pc", 16'(pc_out), 16'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
